// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between the controller and the ALU operation sequencer.
// The controller drives the master side; the sequencer implements the slave side.
interface alu_op_sequencer_if #(
  parameter int WIDTH   = 16,
  parameter int STATE_W = 8
);
  logic               start;
  logic [STATE_W-1:0] controller_state;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               clr_err;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic [3:0]         control;
  logic               div_by_zero;
  logic               illegal_state;

  modport master (
    output start, controller_state, a, b, clr_err,
    input  busy, done, result, control, div_by_zero, illegal_state
  );

  modport slave (
    input  start, controller_state, a, b, clr_err,
    output busy, done, result, control, div_by_zero, illegal_state
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU sequencer: decodes the controller state into an ALU command and
// executes it; MUL/DIV iterate one bit per cycle, everything else completes in one.
module alu_op_sequencer #(
  parameter int WIDTH   = 16,
  parameter int STATE_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_op_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_DIVS, OP_AND, OP_OR, OP_NOT,
    OP_NEG, OP_LT, OP_LTE, OP_GT, OP_GTE, OP_EQ, OP_NEQ
  } op_e;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} st_e;

  st_e              st;
  op_e              op_q, dec_op;
  logic             dec_ill, dec_zero, dec_iter, exec_dbz;
  logic [WIDTH-1:0] a_q, b_q, acc, qr, dv, alu_res, trial;
  logic [WIDTH:0]   rem_sh;
  logic [CW-1:0]    cnt;
  int               cs_i;

  always_comb begin
    cs_i    = int'(bus.controller_state);
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    case (cs_i) inside
      [1:4], [6:9], [34:40], 10, 14: dec_op = OP_ADD;
      11, 15:                        dec_op = OP_SUB;
      12, 16:                        dec_op = OP_MUL;
      13:                            dec_op = OP_DIV;
      17:                            dec_op = OP_DIVS;
      18:                            dec_op = OP_AND;
      19:                            dec_op = OP_OR;
      20, 23:                        dec_op = OP_EQ;
      21, 22:                        dec_op = OP_NEQ;
      24:                            dec_op = OP_NOT;
      25:                            dec_op = OP_NEG;
      26, 30:                        dec_op = OP_LT;
      27, 31:                        dec_op = OP_LTE;
      28, 32:                        dec_op = OP_GT;
      29, 33:                        dec_op = OP_GTE;
      default:                       dec_ill = 1'b1;
    endcase
    dec_zero = (dec_op == OP_DIV  && bus.b == '0) ||
               (dec_op == OP_DIVS && bus.a == '0);
    dec_iter = (dec_op inside {OP_MUL, OP_DIV, OP_DIVS}) && !dec_zero;
  end

  // Only zero-divisor divides reach EXEC, so a divide op there means all-ones.
  always_comb begin
    alu_res  = a_q + b_q;
    exec_dbz = 1'b0;
    case (op_q)
      OP_SUB:          alu_res = a_q - b_q;
      OP_AND:          alu_res = a_q & b_q;
      OP_OR:           alu_res = a_q | b_q;
      OP_NOT:          alu_res = ~a_q;
      OP_NEG:          alu_res = '0 - a_q;
      OP_LT:           alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) <  $signed(b_q)};
      OP_LTE:          alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) <= $signed(b_q)};
      OP_GT:           alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) >  $signed(b_q)};
      OP_GTE:          alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) >= $signed(b_q)};
      OP_EQ:           alu_res = {{(WIDTH-1){1'b0}}, a_q == b_q};
      OP_NEQ:          alu_res = {{(WIDTH-1){1'b0}}, a_q != b_q};
      OP_DIV, OP_DIVS: begin alu_res = '1; exec_dbz = 1'b1; end
      default:         alu_res = a_q + b_q;
    endcase
  end

  // Restoring divide step: acc is the partial remainder, qr shifts dividend out / quotient in.
  assign rem_sh = {acc, qr[WIDTH-1]};
  assign trial  = rem_sh[WIDTH-1:0] - dv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st                <= IDLE;
      op_q              <= OP_ADD;
      a_q               <= '0;
      b_q               <= '0;
      acc               <= '0;
      qr                <= '0;
      dv                <= '0;
      cnt               <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.result        <= '0;
      bus.control       <= '0;
      bus.div_by_zero   <= 1'b0;
      bus.illegal_state <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.clr_err) bus.illegal_state <= 1'b0;
      case (st)
        ITER: begin
          if (cnt == CW'(WIDTH)) begin
            bus.result      <= (op_q == OP_MUL) ? acc : qr;
            bus.div_by_zero <= 1'b0;
            bus.done        <= 1'b1;
            bus.busy        <= 1'b0;
            st              <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (op_q == OP_MUL) begin
              if (qr[0]) acc <= acc + dv;
              dv <= dv << 1;
              qr <= qr >> 1;
            end else if (rem_sh >= {1'b0, dv}) begin
              acc <= trial;
              qr  <= {qr[WIDTH-2:0], 1'b1};
            end else begin
              acc <= rem_sh[WIDTH-1:0];
              qr  <= {qr[WIDTH-2:0], 1'b0};
            end
          end
        end
        default: begin
          // Completion and a new accept share this edge for back-to-back throughput.
          if (st == EXEC) begin
            bus.result      <= alu_res;
            bus.div_by_zero <= exec_dbz;
            bus.done        <= 1'b1;
          end
          if (bus.start) begin
            a_q         <= bus.a;
            b_q         <= bus.b;
            op_q        <= dec_op;
            bus.control <= dec_op;
            if (dec_ill) bus.illegal_state <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
            qr          <= (dec_op == OP_DIV) ? bus.a : bus.b;
            dv          <= (dec_op == OP_DIV) ? bus.b : bus.a;
            bus.busy    <= dec_iter;
            st          <= dec_iter ? ITER : EXEC;
          end else begin
            st <= (st == EXEC) ? DONE : IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: transaction-level model checked every cycle, plus
// directed requests whose results and latencies are pinned by hand-computed literals.
module tb_alu_op_sequencer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(W), .STATE_W(8)) bus ();

  alu_op_sequencer #(.WIDTH(W), .STATE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           due;
    logic [W-1:0] res;
    logic         dbz;
  } exp_t;

  exp_t         q[$];
  logic [3:0]   ctab [256];
  bit           legal [256];
  int           cyc    = 0;
  bit           busy_m = 1'b0;
  bit           ill_m  = 1'b0;
  bit           done_m = 1'b0;
  bit           dbz_m  = 1'b0;
  logic [3:0]   ctrl_m = 4'd0;
  logic [W-1:0] res_m  = '0;

  function automatic void build_tables();
    for (int s = 0; s < 256; s++) begin
      legal[s] = (s >= 1 && s <= 40 && s != 5);
      ctab[s]  = 4'd0;
    end
    ctab[11] = 4'd1;  ctab[15] = 4'd1;
    ctab[12] = 4'd2;  ctab[16] = 4'd2;
    ctab[13] = 4'd3;  ctab[17] = 4'd4;
    ctab[18] = 4'd5;  ctab[19] = 4'd6;
    ctab[24] = 4'd7;  ctab[25] = 4'd8;
    ctab[26] = 4'd9;  ctab[30] = 4'd9;
    ctab[27] = 4'd10; ctab[31] = 4'd10;
    ctab[28] = 4'd11; ctab[32] = 4'd11;
    ctab[29] = 4'd12; ctab[33] = 4'd12;
    ctab[20] = 4'd13; ctab[23] = 4'd13;
    ctab[21] = 4'd14; ctab[22] = 4'd14;
  endfunction

  function automatic void model_calc(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] r, output logic z);
    logic [31:0] p;
    shortint     sx, sy;
    sx = x;
    sy = y;
    p  = x * y;
    z  = 1'b0;
    case (c)
      4'd1:  r = x - y;
      4'd2:  r = p[W-1:0];
      4'd3:  if (y == 0) begin r = '1; z = 1'b1; end else r = x / y;
      4'd4:  if (x == 0) begin r = '1; z = 1'b1; end else r = y / x;
      4'd5:  r = x & y;
      4'd6:  r = x | y;
      4'd7:  r = ~x;
      4'd8:  r = -x;
      4'd9:  r = (sx <  sy) ? 16'd1 : 16'd0;
      4'd10: r = (sx <= sy) ? 16'd1 : 16'd0;
      4'd11: r = (sx >  sy) ? 16'd1 : 16'd0;
      4'd12: r = (sx >= sy) ? 16'd1 : 16'd0;
      4'd13: r = (x == y) ? 16'd1 : 16'd0;
      4'd14: r = (x != y) ? 16'd1 : 16'd0;
      default: r = x + y;
    endcase
  endfunction

  task automatic model_step();
    bit         free, long_op;
    exp_t       e;
    logic [3:0] c;
    int         idx;
    if (!rst_n) begin
      q.delete();
      busy_m = 1'b0; ill_m = 1'b0; done_m = 1'b0; dbz_m = 1'b0;
      ctrl_m = 4'd0; res_m = '0;
      return;
    end
    cyc++;
    free   = !busy_m;
    done_m = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e      = q.pop_front();
      res_m  = e.res;
      dbz_m  = e.dbz;
      done_m = 1'b1;
      busy_m = 1'b0;
    end
    if (bus.clr_err) ill_m = 1'b0;
    if (bus.start && free) begin
      idx = int'(bus.controller_state);
      c   = legal[idx] ? ctab[idx] : 4'd0;
      if (!legal[idx]) ill_m = 1'b1;
      model_calc(c, bus.a, bus.b, e.res, e.dbz);
      long_op = (c == 4'd2 || c == 4'd3 || c == 4'd4) && !e.dbz;
      e.due   = cyc + (long_op ? W + 1 : 1);
      q.push_back(e);
      ctrl_m = c;
      busy_m = long_op;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("done",          32'(bus.done),          32'(done_m));
    chk("busy",          32'(bus.busy),          32'(busy_m));
    chk("control",       32'(bus.control),       32'(ctrl_m));
    chk("illegal_state", 32'(bus.illegal_state), 32'(ill_m));
    chk("result",        32'(bus.result),        32'(res_m));
    if (done_m) chk("div_by_zero", 32'(bus.div_by_zero), 32'(dbz_m));
  end

  // ---------------- directed stimulus ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle where done is seen.
  task automatic req(input logic [7:0] st, input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input logic [W-1:0] er, input int el, input string nm);
    int n;
    bus.start = 1'b1; bus.controller_state = st; bus.a = aa; bus.b = bb;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.done && n < 60);
    chk({nm, " latency"}, 32'(n), 32'(el));
    chk({nm, " result"}, 32'(bus.result), 32'(er));
  endtask

  initial begin
    int nd;
    bus.start = 1'b0; bus.controller_state = '0; bus.a = '0; bus.b = '0; bus.clr_err = 1'b0;
    build_tables();
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",    32'(bus.busy),          32'd0);
    chk("reset done",    32'(bus.done),          32'd0);
    chk("reset result",  32'(bus.result),        32'd0);
    chk("reset control", 32'(bus.control),       32'd0);
    chk("reset dbz",     32'(bus.div_by_zero),   32'd0);
    chk("reset illegal", 32'(bus.illegal_state), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    req(8'd12, 16'd300, 16'd7, 16'h0834, 17, "mul 300*7");
    req(8'd17, 16'd5, 16'd100, 16'd20, 17, "divswap 100/5");
    chk("divswap control", 32'(bus.control), 32'd4);
    req(8'd13, 16'd9, 16'd0, 16'hFFFF, 1, "div by zero");
    chk("div by zero flag", 32'(bus.div_by_zero), 32'd1);
    req(8'd13, 16'd100, 16'd7, 16'd14, 17, "div 100/7");
    chk("div flag clear", 32'(bus.div_by_zero), 32'd0);
    req(8'd28, 16'hFFFF, 16'd1, 16'd0, 1, "gt -1>1");
    req(8'd32, 16'd1, 16'hFFFF, 16'd1, 1, "gt 1>-1");
    req(8'd20, 16'h1234, 16'h1234, 16'd1, 1, "eq");
    req(8'd11, 16'd3, 16'd5, 16'hFFFE, 1, "sub 3-5");
    req(8'd25, 16'd1, 16'd0, 16'hFFFF, 1, "negate 1");
    req(8'd24, 16'h00F0, 16'd0, 16'hFF0F, 1, "not");
    req(8'd40, 16'd10, 16'd20, 16'd30, 1, "add state 40");

    // illegal state handling
    req(8'd5, 16'd2, 16'd3, 16'd5, 1, "illegal 5");
    chk("illegal control", 32'(bus.control), 32'd0);
    chk("illegal set", 32'(bus.illegal_state), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("illegal held", 32'(bus.illegal_state), 32'd1);
    bus.clr_err = 1'b1;
    @(posedge clk); #1;
    bus.clr_err = 1'b0;
    chk("illegal cleared", 32'(bus.illegal_state), 32'd0);
    bus.clr_err = 1'b1; bus.start = 1'b1; bus.controller_state = 8'd41; bus.a = 16'd1; bus.b = 16'd1;
    @(posedge clk); #1;
    bus.clr_err = 1'b0; bus.start = 1'b0;
    chk("clr vs set", 32'(bus.illegal_state), 32'd1);
    @(posedge clk); #1;
    chk("illegal 41 result", 32'(bus.result), 32'd2);
    bus.clr_err = 1'b1;
    @(posedge clk); #1;
    bus.clr_err = 1'b0;

    // back-to-back single-cycle ops with start held high
    bus.start = 1'b1; bus.controller_state = 8'd10; bus.a = 16'd6; bus.b = 16'd3;
    @(posedge clk); #1;
    bus.controller_state = 8'd11;
    @(posedge clk); #1;
    chk("b2b done0", 32'(bus.done), 32'd1);
    chk("b2b add", 32'(bus.result), 32'd9);
    bus.controller_state = 8'd18;
    @(posedge clk); #1;
    chk("b2b done1", 32'(bus.done), 32'd1);
    chk("b2b sub", 32'(bus.result), 32'd3);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("b2b done2", 32'(bus.done), 32'd1);
    chk("b2b and", 32'(bus.result), 32'd2);

    // start during ITER is ignored
    bus.start = 1'b1; bus.controller_state = 8'd12; bus.a = 16'd300; bus.b = 16'd7;
    @(posedge clk); #1;
    bus.controller_state = 8'd10; bus.a = 16'd1; bus.b = 16'd1;
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin
        nd++;
        chk("mul during start result", 32'(bus.result), 32'h0834);
      end
    end
    chk("single done during iter", 32'(nd), 32'd1);

    // reset in the middle of an ITER
    bus.start = 1'b1; bus.controller_state = 8'd16; bus.a = 16'd9; bus.b = 16'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort busy",    32'(bus.busy),    32'd0);
    chk("abort done",    32'(bus.done),    32'd0);
    chk("abort result",  32'(bus.result),  32'd0);
    chk("abort control", 32'(bus.control), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) nd++;
    end
    chk("no done after abort", 32'(nd), 32'd0);
    req(8'd1, 16'd2, 16'd3, 16'd5, 1, "post-reset add");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
